// File: rtl/pong_pkg.sv
// Shared types and board constants for the paddle game.
package pong_pkg;

    typedef enum logic [2:0] {
        PhIdle  = 3'd0,
        PhServe = 3'd1,
        PhRally = 3'd2,
        PhPoint = 3'd3,
        PhOver  = 3'd4
    } phase_e;

    localparam int unsigned ScreenW    = 480;
    localparam int unsigned ScreenH    = 272;
    localparam int unsigned Wy         = 100;
    localparam int unsigned MinWy      = 50;
    localparam int unsigned StartSpeed = 1;
    localparam int unsigned MaxSpeed   = 4;
    localparam int unsigned Wx         = 5;
    localparam int unsigned Br         = 14;
    localparam int unsigned TimerW     = 16;

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down counter that advances only on frame ticks; done marks the final tick.
module tick_down_counter
    import pong_pkg::*;
#(
    parameter int unsigned Width = TimerW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    output logic             done_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (tick_i && count_q != '0) begin
            count_q <= count_q - Width'(1);
        end
    end

    // Asserted while the counter sits at 1: the next tick is the expiring one.
    assign done_o = (count_q == Width'(1));

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: game phase, scores, serve direction, phase timers and difficulty level.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned PointsToWin = 5,
    parameter int unsigned ServeTicks  = 100,
    parameter int unsigned PointTicks  = 50,
    parameter int unsigned OverTicks   = 200,
    parameter int unsigned LevelPeriod = 512,
    parameter int unsigned MaxLevel    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_i,
    input  logic       launch_i,
    input  logic       miss_left_i,
    input  logic       miss_right_i,
    output logic [2:0] phase_o,
    output logic       ball_reset_o,
    output logic       play_en_o,
    output logic       serve_dir_o,
    output logic [3:0] score_left_o,
    output logic [3:0] score_right_o,
    output logic       winner_o,
    output logic [3:0] level_o,
    output logic [8:0] paddle_height_o,
    output logic [2:0] ball_speed_o,
    output logic [7:0] led_o
);

    phase_e            phase_q;
    logic              ball_reset_q, play_en_q, serve_dir_q, winner_q;
    logic [3:0]        score_left_q, score_right_q, level_q;
    logic [15:0]       lvl_cnt_q;
    logic              timer_load, timer_done, any_miss, match_won;
    logic [TimerW-1:0] timer_value;
    logic [8:0]        shrink;
    logic [2:0]        speed_raw;

    assign any_miss  = miss_left_i | miss_right_i;
    assign match_won = (score_left_q == 4'(PointsToWin)) || (score_right_q == 4'(PointsToWin));

    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (tick_i) begin
            case (phase_q)
                PhIdle: if (launch_i) begin
                    timer_load  = 1'b1;
                    timer_value = TimerW'(ServeTicks);
                end
                PhRally: if (any_miss) begin
                    timer_load  = 1'b1;
                    timer_value = TimerW'(PointTicks);
                end
                PhPoint: if (timer_done) begin
                    timer_load  = 1'b1;
                    timer_value = match_won ? TimerW'(OverTicks) : TimerW'(ServeTicks);
                end
                default: ;
            endcase
        end
    end

    tick_down_counter #(
        .Width(TimerW)
    ) u_phase_timer (
        .clock       (clock),
        .reset       (reset),
        .tick_i      (tick_i),
        .load_i      (timer_load),
        .load_value_i(timer_value),
        .done_o      (timer_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q       <= PhIdle;
            ball_reset_q  <= 1'b1;
            play_en_q     <= 1'b0;
            serve_dir_q   <= 1'b1;
            winner_q      <= 1'b0;
            score_left_q  <= '0;
            score_right_q <= '0;
            level_q       <= '0;
            lvl_cnt_q     <= '0;
        end else if (tick_i) begin
            unique case (phase_q)
                PhIdle: if (launch_i) begin
                    phase_q     <= PhServe;
                    serve_dir_q <= 1'b1;
                end
                PhServe: if (timer_done) begin
                    phase_q      <= PhRally;
                    ball_reset_q <= 1'b0;
                    play_en_q    <= 1'b1;
                end
                PhRally: begin
                    if (lvl_cnt_q == 16'(LevelPeriod - 1)) begin
                        lvl_cnt_q <= '0;
                        if (level_q < 4'(MaxLevel)) level_q <= level_q + 4'd1;
                    end else begin
                        lvl_cnt_q <= lvl_cnt_q + 16'd1;
                    end
                    // A simultaneous double miss scores nobody and replays the rally.
                    if (miss_left_i && !miss_right_i) begin
                        score_right_q <= score_right_q + 4'd1;
                        serve_dir_q   <= 1'b0;
                    end else if (miss_right_i && !miss_left_i) begin
                        score_left_q <= score_left_q + 4'd1;
                        serve_dir_q  <= 1'b1;
                    end
                    if (any_miss) begin
                        phase_q      <= PhPoint;
                        ball_reset_q <= 1'b1;
                        play_en_q    <= 1'b0;
                    end
                end
                PhPoint: if (timer_done) begin
                    if (match_won) begin
                        phase_q  <= PhOver;
                        winner_q <= (score_right_q == 4'(PointsToWin));
                    end else begin
                        phase_q   <= PhServe;
                        level_q   <= '0;
                        lvl_cnt_q <= '0;
                    end
                end
                PhOver: if (timer_done) begin
                    phase_q       <= PhIdle;
                    winner_q      <= 1'b0;
                    score_left_q  <= '0;
                    score_right_q <= '0;
                    level_q       <= '0;
                    lvl_cnt_q     <= '0;
                end
                default: phase_q <= PhIdle;
            endcase
        end
    end

    always_comb begin
        shrink          = 9'(level_q) * 9'd6;
        paddle_height_o = (shrink > 9'(Wy - MinWy)) ? 9'(MinWy) : 9'(Wy) - shrink;
        speed_raw       = 3'(StartSpeed) + {1'b0, level_q[3:2]};
        ball_speed_o    = (speed_raw > 3'(MaxSpeed)) ? 3'(MaxSpeed) : speed_raw;
        for (int i = 0; i < 8; i++) begin
            led_o[i] = (level_q > 4'(i));
        end
    end

    assign phase_o       = phase_q;
    assign ball_reset_o  = ball_reset_q;
    assign play_en_o     = play_en_q;
    assign serve_dir_o   = serve_dir_q;
    assign score_left_o  = score_left_q;
    assign score_right_o = score_right_q;
    assign winner_o      = winner_q;
    assign level_o       = level_q;

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the two-player paddle game on the 480×272 LCD board. It owns the game phase, both scores, serve direction, pauses and the difficulty schedule. Each rally gets shorter paddles and a faster ball the longer it lasts. It sits between the 100 Hz strobe generator, the player keys and the playfield/ball datapath. The playfield reports misses and consumes this block's control and configuration outputs; scores drive the seven-segment display and level drives the LEDs.

## Interface
Parameters:
- points_to_win, 5, score that ends the match (1..15)
- serve_ticks, 100, ticks the ball is held centred before a rally
- point_ticks, 50, pause after a point
- over_ticks, 200, result display time
- level_period, 512, rally ticks per difficulty step
- max_level, 8, level saturation value

Ports:
- clock  in  1  system clock; reset, synchronous, active-high
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle frame strobe (100 Hz)
- launch  in  1  both-player start request (level)
- miss_left  in  1  ball crossed left edge: point to right player
- miss_right  in  1  ball crossed right edge: point to left player
- phase  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4
- ball_reset  out  1  playfield must hold the ball at centre
- play_en  out  1  ball and paddles may move
- serve_dir  out  1  1 = first ball motion toward right
- score_left, score_right  out  4 each  scores
- winner  out  1  1 = right player won; valid in OVER
- level  out  4  difficulty level, 0..max_level
- paddle_height  out  9  current paddle height in pixels
- ball_speed  out  3  pixels per tick
- led  out  8  thermometer of level (bit i set when level > i)

## Operation
- All inputs are sampled only on cycles with tick=1; the state, counters and scores change only on those edges.
- IDLE: ball_reset=1, play_en=0, scores 0, level 0. On launch, go to SERVE, serve_dir=1, timer=serve_ticks.
- SERVE: ball_reset=1, play_en=0. Level and level counter are held at 0. Each tick decrements timer; on the tick with timer==1, go to RALLY.
- RALLY: play_en=1, ball_reset=0.
  - The level counter counts ticks. When it equals level_period-1 it clears and level increments, saturating at max_level.
  - miss_left alone: score_right+1, serve_dir=0.
  - miss_right alone: score_left+1, serve_dir=1.
  - Both misses on the same tick: no score change and serve_dir unchanged; the rally is replayed.
  - Any miss: go to POINT, timer=point_ticks.
  - launch is ignored.
- POINT: ball_reset=1. When timer expires:
  - If either score equals points_to_win, go to OVER with winner=(score_right==points_to_win) and timer=over_ticks.
  - Otherwise go to SERVE with timer=serve_ticks.
- OVER: ball_reset=1, scores frozen. When timer expires, go to IDLE and clear scores and winner. launch is ignored.
- paddle_height = 100 − level·6, giving 100 at level 0 and 52 at level 8, never below 50.
- ball_speed = 1 + level[3:2], giving 1/2/3 and capped at 4.
- Scores never wrap. Increments are impossible past points_to_win because the match ends there.
- Misses outside RALLY are ignored.

## Timing
- Reset values: phase IDLE, ball_reset 1, play_en 0, serve_dir 1, scores 0, winner 0, level 0, paddle_height 100, ball_speed 1, led 0.
- Reset mid-match returns to these values at the next edge, regardless of tick.
- All outputs are registered or decoded from registered state; there is no combinational input→output path.
- A miss on tick cycle N gives the updated score and phase=POINT from cycle N+1.
- SERVE lasts exactly serve_ticks ticks, POINT exactly point_ticks, OVER exactly over_ticks.
- A level step takes effect the cycle after the level_period-th rally tick.
- paddle_height, ball_speed and led update in the same cycle as level.

## Structure
- Shared package pong_pkg holds:
  - the phase enum typedef
  - screen size 480/272
  - paddle height constants wy=100 and min_wy=50
  - speed constants start_speed=1 and max_speed=4
  - paddle width wx=5 and ball size br=14
- One sub-module, tick_down_counter: loadable down counter advancing on tick with a done flag. It is used for the phase timers.
- The level counter stays inline.

## Test plan
- Reset, then launch on a tick → SERVE, ball_reset=1. RALLY is entered exactly 100 ticks later with play_en=1.
- In RALLY, assert miss_left on a tick → next cycle score_right=1, serve_dir=0, phase POINT. After 50 ticks, SERVE.
- Hold RALLY for 4·512 ticks → level=4, paddle_height=76, ball_speed=2, led=0x0F. After 8·512 and beyond: level=8, paddle_height=52, ball_speed=3, led=0xFF.
- Both misses on the same tick → scores unchanged, POINT then SERVE. Misses asserted during SERVE/POINT have no effect.
- Left player scores 5 → OVER, winner=0, scores 5:x held for 200 ticks, then IDLE with scores 0.
- Assert reset mid-RALLY with score 3:2, level 5 → all outputs at their reset values next cycle.
